det_rr_scan_ctrl: RTL and testbench

Scheduler that shares one bit-serial 110101-style sequence detector among NREQ requesters. It round-robin arbitrates word requests over valid/ready, then shifts the granted word MSB-first through an embedded overlapping pattern matcher. It reports each match with requester ID and bit position, and emits a per-word done/hit-count summary. It sits between parallel word producers and match-consuming logic, replacing the free-running single-stream serial detector.

---
 rtl/det_rr_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_det_rr_scan_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/det_rr_scan_ctrl.sv
// Round-robin scheduler that shares one bit-serial overlapping pattern detector among NREQ
// word requesters. Define DET_MATCH_CNT_EN to add saturating per-requester match counters.
module det_rr_scan_ctrl #(
    parameter int unsigned        NREQ    = 2,
    parameter int unsigned        WIDTH   = 8,
    parameter int unsigned        PLEN    = 6,
    parameter logic [PLEN-1:0]    PATTERN = 6'b110101,
    parameter int unsigned        CNT_W   = 8,
    localparam int unsigned       ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int unsigned       POS_W   = $clog2(WIDTH),
    localparam int unsigned       HIT_W   = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  busy,
    output logic                  match,
    output logic [ID_W-1:0]       match_id,
    output logic [POS_W-1:0]      match_pos,
    output logic                  word_done,
`ifdef DET_MATCH_CNT_EN
    output logic [HIT_W-1:0]      word_hits,
    output logic [NREQ*CNT_W-1:0] match_cnt
`else
    output logic [HIT_W-1:0]      word_hits
`endif
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [PLEN-1:0]   hist_q, hist_d;
    logic [POS_W-1:0]  k_q, k_d;
    logic [HIT_W-1:0]  hits_q, hits_d;
    logic              match_q, match_d;
    logic [POS_W-1:0]  mpos_q, mpos_d;
    logic [ID_W-1:0]   mid_q, mid_d;

    logic [ID_W-1:0]   pick_id;
    logic              transfer;
    logic [PLEN-1:0]   hist_new;
    logic              hit;

    // First valid requester strictly after the last grant, wrapping around.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] v,
                                                input logic [ID_W-1:0] last);
        logic [ID_W-1:0] sel;
        logic [NREQ-1:0] sh;
        logic            found;
        int unsigned     idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last) + i) % NREQ;
            sh  = v >> idx;
            if (!found && sh[0]) begin
                sel   = ID_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        pick_id   = rr_pick(req_valid, last_q);
        req_ready = '0;
        if (rstn && (state_q == StIdle) && (|req_valid)) begin
            req_ready = NREQ'(1) << pick_id;
        end
        transfer = |(req_valid & req_ready);
    end

    assign hist_new = {hist_q[PLEN-2:0], word_q[WIDTH-1]};
    // Early bits are masked so the cleared history cannot fake a hit.
    assign hit = (state_q == StShift) && (32'(k_q) >= PLEN - 1) && (hist_new == PATTERN);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        id_d    = id_q;
        last_d  = last_q;
        hist_d  = hist_q;
        k_d     = k_q;
        hits_d  = hits_q;
        match_d = 1'b0;
        mpos_d  = mpos_q;
        mid_d   = mid_q;
        unique case (state_q)
            StIdle: begin
                if (transfer) begin
                    word_d  = req_data[32'(pick_id) * WIDTH +: WIDTH];
                    id_d    = pick_id;
                    last_d  = pick_id;
                    hist_d  = '0;
                    k_d     = '0;
                    hits_d  = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                word_d = word_q << 1;
                hist_d = hist_new;
                k_d    = k_q + POS_W'(1);
                if (hit) begin
                    match_d = 1'b1;
                    mpos_d  = k_q;
                    mid_d   = id_q;
                    hits_d  = hits_q + HIT_W'(1);
                end
                if (32'(k_q) == WIDTH - 1) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            word_q  <= '0;
            id_q    <= '0;
            last_q  <= ID_W'(NREQ - 1);
            hist_q  <= '0;
            k_q     <= '0;
            hits_q  <= '0;
            match_q <= 1'b0;
            mpos_q  <= '0;
            mid_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            id_q    <= id_d;
            last_q  <= last_d;
            hist_q  <= hist_d;
            k_q     <= k_d;
            hits_q  <= hits_d;
            match_q <= match_d;
            mpos_q  <= mpos_d;
            mid_q   <= mid_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign word_done = (state_q == StDone);
    assign word_hits = word_done ? hits_q : '0;
    assign match     = match_q;
    assign match_pos = mpos_q;
    assign match_id  = mid_q;

`ifdef DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q [NREQ];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (hit && (32'(id_q) == i) && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        match_cnt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            match_cnt[i * CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_det_rr_scan_ctrl.sv
// Self-checking bench for det_rr_scan_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a cycle-offset reference model.
module tb_det_rr_scan_ctrl;

    localparam int NREQ  = 2;
    localparam int WIDTH = 8;
    localparam int PLEN  = 6;
    localparam logic [PLEN-1:0] PATTERN = 6'b110101;
    localparam int CNT_W = 2;
    localparam int ID_W  = 1;
    localparam int POS_W = 3;
    localparam int HIT_W = 4;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  busy, match, word_done;
    logic [ID_W-1:0]       match_id;
    logic [POS_W-1:0]      match_pos;
    logic [HIT_W-1:0]      word_hits;
`ifdef DET_MATCH_CNT_EN
    logic [NREQ*CNT_W-1:0] match_cnt;
`endif

    int checks = 0;
    int errors = 0;

    det_rr_scan_ctrl #(
        .NREQ(NREQ), .WIDTH(WIDTH), .PLEN(PLEN), .PATTERN(PATTERN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .busy(busy), .match(match), .match_id(match_id),
        .match_pos(match_pos), .word_done(word_done),
`ifdef DET_MATCH_CNT_EN
        .word_hits(word_hits), .match_cnt(match_cnt)
`else
        .word_hits(word_hits)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: c = cycles since the transfer cycle (0 = idle).
    int              c = 0;
    int              last = NREQ - 1;
    int              cur_id = 0;
    int              cur_hits = 0;
    bit              hit_at [WIDTH];
    int              hold_id = 0;
    int              hold_pos = 0;
    int              mcnt [NREQ];
    bit              started = 0;

    function automatic int rr_model(input logic [NREQ-1:0] v, input int lg);
        for (int i = 1; i <= NREQ; i++) begin
            if (v[(lg + i) % NREQ]) return (lg + i) % NREQ;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        bit              exp_match;
        bit              exp_done;
        int              who;
        logic [31:0]     word, win;
        exp_ready = '0;
        who = rr_model(req_valid, last);
        if (c == 0 && rstn && who >= 0) exp_ready[who] = 1'b1;
        exp_match = (c >= 2 && c <= WIDTH + 1) ? hit_at[c - 2] : 1'b0;
        exp_done  = (c == WIDTH + 1);
        if (started) begin
            if (exp_match) begin
                hold_id  = cur_id;
                hold_pos = c - 2;
                if (mcnt[cur_id] < (1 << CNT_W) - 1) mcnt[cur_id]++;
            end
            chk("ready", 32'(req_ready), 32'(exp_ready));
            chk("busy", 32'(busy), 32'(c >= 1));
            chk("match", 32'(match), 32'(exp_match));
            chk("match_id", 32'(match_id), 32'(hold_id));
            chk("match_pos", 32'(match_pos), 32'(hold_pos));
            chk("word_done", 32'(word_done), 32'(exp_done));
            chk("word_hits", 32'(word_hits), exp_done ? 32'(cur_hits) : 32'd0);
`ifdef DET_MATCH_CNT_EN
            for (int i = 0; i < NREQ; i++) begin
                chk("match_cnt", 32'(match_cnt[i * CNT_W +: CNT_W]), 32'(mcnt[i]));
            end
`endif
        end
        if (!rstn) begin
            c = 0; last = NREQ - 1; hold_id = 0; hold_pos = 0; started = 1;
            for (int i = 0; i < NREQ; i++) mcnt[i] = 0;
        end else if (started) begin
            if (c == 0) begin
                if (exp_ready != 0) begin
                    cur_id = who;
                    last = who;
                    word = 32'(req_data[who * WIDTH +: WIDTH]);
                    cur_hits = 0;
                    for (int k = 0; k < WIDTH; k++) begin
                        hit_at[k] = 1'b0;
                        if (k >= PLEN - 1) begin
                            win = (word >> (WIDTH - 1 - k)) & ((32'd1 << PLEN) - 1);
                            hit_at[k] = (win[PLEN-1:0] == PATTERN);
                            if (hit_at[k]) cur_hits++;
                        end
                    end
                    c = 1;
                end
            end else begin
                c = (c == WIDTH + 1) ? 0 : c + 1;
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] w;
        int               off, evts;
        rstn = 1'b0;
        req_valid = '1;
        req_data = '0;
        repeat (5) @(posedge clk);
        #1 rstn = 1'b1;
        req_valid = 2'b11;
        req_data = {8'h35, 8'hD4};
        @(negedge clk); chk("t0_grant_req0", 32'(req_ready), 32'h1);
        repeat (7) @(negedge clk);
        chk("d4_match", 32'(match), 32'h1);
        chk("d4_pos", 32'(match_pos), 32'h5);
        chk("d4_id", 32'(match_id), 32'h0);
        repeat (2) @(negedge clk);
        chk("d4_done", 32'(word_done), 32'h1);
        chk("d4_hits", 32'(word_hits), 32'h1);
        @(negedge clk); chk("t10_grant_req1", 32'(req_ready), 32'h2);
        @(posedge clk); #1 req_valid = 2'b01; req_data[7:0] = 8'h0D;
        repeat (9) @(negedge clk);
        chk("35_match", 32'(match), 32'h1);
        chk("35_pos", 32'(match_pos), 32'h7);
        chk("35_id", 32'(match_id), 32'h1);
        chk("35_done", 32'(word_done), 32'h1);
        chk("35_hits", 32'(word_hits), 32'h1);
        @(negedge clk); chk("t20_grant_req0", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_data[7:0] = 8'h5F;
        repeat (9) @(negedge clk);
        chk("0d_done", 32'(word_done), 32'h1);
        chk("0d_hits", 32'(word_hits), 32'h0);
        @(negedge clk); chk("t30_grant_req0", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (9) @(negedge clk);
        chk("5f_done", 32'(word_done), 32'h1);
        chk("5f_hits", 32'(word_hits), 32'h0);

        // Reset while bit 3 of a matching word is being shifted.
        @(posedge clk); #1 req_valid = 2'b01; req_data[7:0] = 8'hD4;
        repeat (4) @(posedge clk);
        #1 rstn = 1'b0; req_valid = 2'b00;
        @(posedge clk); #1 rstn = 1'b1;
        evts = 0;
        repeat (12) begin
            @(negedge clk);
            if (match || word_done) evts++;
        end
        chk("midrst_quiet", 32'(evts), 32'h0);

        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            rstn = ($urandom_range(0, 299) != 0);
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                w = WIDTH'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    off = $urandom_range(0, WIDTH - PLEN);
                    w[off +: PLEN] = PATTERN;
                end
                req_data[i * WIDTH +: WIDTH] = w;
            end
        end
        @(posedge clk); #1 req_valid = '0; rstn = 1'b1;
        repeat (WIDTH + 4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
